emu_replay_port_unpack: RTL

Host-to-model replay port: the receiving end of the trace path, carrying data in the opposite direction. It accepts a fixed-width word stream from the host-side replay DMA, reassembles each group of words into one `DATA_WIDTH` payload, and buffers payloads in a small FIFO. It presents them to the emulated model as an outbound data channel with a valid/ready handshake. The port sits between the platform stream interconnect and a model's `__emu_channel_direction = "out"` data channel.

---
 rtl/emu_replay_port_unpack.sv | 121 ++++++++++++
 1 files changed

// File: rtl/emu_replay_port_unpack.sv
// Host-to-model replay port: reassembles STREAM_WIDTH host words into DATA_WIDTH payloads and queues them for the model.
// Optional build macro: EMU_REPLAY_PORT_PADCHECK_EN (sticky flag for non-zero discarded bits on the last word).
module emu_replay_port_unpack #(
    parameter int unsigned DATA_WIDTH   = 1,
    parameter int unsigned STREAM_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    replay_valid,
    output logic                    replay_ready,
    input  logic [STREAM_WIDTH-1:0] replay_data,
    output logic                    tk_data_valid,
    input  logic                    tk_data_ready,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    pad_error
);

    localparam int unsigned BEATS  = (DATA_WIDTH + STREAM_WIDTH - 1) / STREAM_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned PAD_W  = BEATS * STREAM_WIDTH - DATA_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0]     beat;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] payload_c;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic is_last;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push;
    logic pop;

    assign is_last    = (beat == LAST_BEAT);
    assign fifo_full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Ready depends only on registered state; a pop never frees a slot in the same cycle.
    assign replay_ready  = !is_last || !fifo_full;
    assign accept        = replay_valid && replay_ready;
    assign push          = accept && is_last;
    assign tk_data_valid = !fifo_empty;
    assign pop           = tk_data_valid && tk_data_ready;
    assign data          = mem[rd_ptr[IDX_W-1:0]];

    // Current word merged over the partial assembly at its beat position; bits past DATA_WIDTH fall away.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_merge
        assign payload_c[i] = (beat == BEAT_W'(i / STREAM_WIDTH)) ? replay_data[i % STREAM_WIDTH]
                                                                  : asm_q[i];
    end

    // Beat counter and assembly register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat  <= '0;
            asm_q <= '0;
        end else if (accept) begin
            if (is_last) begin
                beat  <= '0;
                asm_q <= '0;
            end else begin
                beat  <= beat + BEAT_W'(1);
                asm_q <= payload_c;
            end
        end
    end

    // Payload FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload FIFO storage, cleared on reset so data reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= payload_c;
        end
    end

`ifdef EMU_REPLAY_PORT_PADCHECK_EN
    if (PAD_W > 0) begin : g_pad
        logic pad_hit;
        assign pad_hit = |replay_data[STREAM_WIDTH-1 -: PAD_W];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pad_error <= 1'b0;
            end else if (push && pad_hit) begin
                pad_error <= 1'b1;
            end
        end
    end else begin : g_no_pad
        assign pad_error = 1'b0;
    end
`else
    logic unused_replay;
    assign unused_replay = ^replay_data;
    assign pad_error     = 1'b0;
`endif

endmodule
